// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns CPU writes to the LCD register into timed HD44780 bus cycles (setup, E pulse, hold, exec wait)
// with a one-deep pending slot. Define LCD_INIT_EN to add a power-up wait plus a fixed init command sequence.
module lcd_ctrl #(
    parameter int T_SETUP     = 4,
    parameter int T_PULSE     = 12,
    parameter int T_HOLD      = 4,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 80000,
    parameter int T_PWRUP     = 750000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_word,
    input  logic        i_lcd_wr,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic        o_overflow
);
    localparam int M0    = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int M1    = (M0 > T_HOLD) ? M0 : T_HOLD;
    localparam int M2    = (M1 > T_EXEC) ? M1 : T_EXEC;
    localparam int M3    = (M2 > T_EXEC_LONG) ? M2 : T_EXEC_LONG;
    localparam int T_MAX = (M3 > T_PWRUP) ? M3 : T_PWRUP;
    localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [2:0] {
`ifdef LCD_INIT_EN
        INIT_WAIT,
`endif
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } state_t;

    typedef struct packed {
        logic       on;
        logic       rs;
        logic [7:0] data;
    } cmd_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    cmd_t          act_q, act_d;
    cmd_t          pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic          en_q, en_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;

    cmd_t          wr_cmd;
    cmd_t          start_cmd;
    logic          start;
    logic          pend_take;
    logic          is_long;
    logic          unused_word_bits;

`ifdef LCD_INIT_EN
    logic [1:0]    idx_q, idx_d;
    logic          more_q, more_d;

    function automatic cmd_t init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = '{on: 1'b1, rs: 1'b0, data: 8'h38};
            2'd1:    init_cmd = '{on: 1'b1, rs: 1'b0, data: 8'h0C};
            2'd2:    init_cmd = '{on: 1'b1, rs: 1'b0, data: 8'h01};
            default: init_cmd = '{on: 1'b1, rs: 1'b0, data: 8'h06};
        endcase
    endfunction
`endif

    assign wr_cmd           = '{on: i_lcd_word[31], rs: i_lcd_word[8], data: i_lcd_word[7:0]};
    assign unused_word_bits = ^i_lcd_word[30:9];
    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    assign is_long          = !act_q.rs && (act_q.data[7:2] == 6'd0) && (act_q.data[1:0] != 2'd0);

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ovf_d      = ovf_q;
        start      = 1'b0;
        start_cmd  = pend_q;
        pend_take  = 1'b0;
`ifdef LCD_INIT_EN
        idx_d      = idx_q;
        more_d     = more_q;
`endif

        case (state_q)
`ifdef LCD_INIT_EN
            INIT_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    start     = 1'b1;
                    start_cmd = init_cmd(2'd0);
                    idx_d     = 2'd1;
                    more_d    = 1'b1;
                end
            end
`endif
            IDLE: begin
                // A word can only be left pending here if it landed on the final EXEC edge.
                if (pend_vld_q) begin
                    start     = 1'b1;
                    pend_take = 1'b1;
                end else if (i_lcd_wr) begin
                    start     = 1'b1;
                    start_cmd = wr_cmd;
                end
            end
            SETUP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = PULSE;
                    cnt_d   = CW'(T_PULSE - 1);
                end
            end
            PULSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = HOLD;
                    cnt_d   = CW'(T_HOLD - 1);
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = EXEC;
                    cnt_d   = is_long ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
`ifdef LCD_INIT_EN
                else if (more_q) begin
                    start     = 1'b1;
                    start_cmd = init_cmd(idx_q);
                    idx_d     = idx_q + 2'd1;
                    more_d    = (idx_q != 2'd3);
                end
`endif
                else if (pend_vld_q) begin
                    start     = 1'b1;
                    pend_take = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pend_take) begin
            pend_vld_d = 1'b0;
        end

        if (i_lcd_wr && !(state_q == IDLE && !pend_vld_q)) begin
            if (!pend_vld_q || pend_take) begin
                pend_vld_d = 1'b1;
                pend_d     = wr_cmd;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (start) begin
            state_d = SETUP;
            cnt_d   = CW'(T_SETUP - 1);
            act_d   = start_cmd;
        end

        en_d   = (state_d == PULSE);
        busy_d = (state_d != IDLE) || pend_vld_d;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
`ifdef LCD_INIT_EN
            state_q <= INIT_WAIT;
            cnt_q   <= CW'(T_PWRUP - 1);
            busy_q  <= 1'b1;
            idx_q   <= 2'd0;
            more_q  <= 1'b0;
`else
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
`endif
            act_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            en_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
`ifdef LCD_INIT_EN
            idx_q      <= idx_d;
            more_q     <= more_d;
`endif
        end
    end

    assign o_lcd_data = act_q.data;
    assign o_lcd_rs   = act_q.rs;
    assign o_lcd_on   = act_q.on;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = en_q;
    assign o_busy     = busy_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: directed timing scenarios followed by random traffic, all outputs compared every cycle
// against a transaction-level model (active word with start time, pending slot, optional init queue).
module tb_lcd_ctrl;
    localparam int TS  = 2;
    localparam int TP  = 3;
    localparam int TH  = 2;
    localparam int TE  = 5;
    localparam int TEL = 20;
    localparam int TPW = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic [31:0] word;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy, o_overflow;

    int    checks   = 0;
    int    failures = 0;
    string phase    = "reset";

    // Model: the word currently on the bus, when it started, how long it occupies the bus.
    int         e = 0;
    bit         m_act, m_wait, m_pend_v, m_ovf;
    int         m_start, m_dur;
    logic [9:0] m_pend_w;
    logic [9:0] m_cur;
    logic [9:0] init_q[$];

    lcd_ctrl #(
        .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH),
        .T_EXEC(TE), .T_EXEC_LONG(TEL), .T_PWRUP(TPW)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_lcd_word(word), .i_lcd_wr(wr),
        .o_lcd_data(o_lcd_data), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
        .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on), .o_busy(o_busy), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    function automatic int word_dur(input logic [9:0] w);
        logic [7:0] d;
        d = w[7:0];
        if (!w[8] && d[7:2] == 6'd0 && d[1:0] != 2'd0) return TS + TP + TH + TEL;
        return TS + TP + TH + TE;
    endfunction

    function automatic void m_begin(input logic [9:0] w);
        m_act   = 1'b1;
        m_wait  = 1'b0;
        m_start = e;
        m_dur   = word_dur(w);
        m_cur   = w;
    endfunction

    function automatic void model_edge();
        bit         ending, idle_before, pend_before, took;
        logic [9:0] w;
        e++;
        w = {word[31], word[8], word[7:0]};
        if (rst) begin
            m_pend_v = 1'b0;
            m_ovf    = 1'b0;
            m_cur    = '0;
            init_q.delete();
`ifdef LCD_INIT_EN
            m_act   = 1'b1;
            m_wait  = 1'b1;
            m_start = e;
            m_dur   = TPW;
            init_q  = '{10'h238, 10'h20C, 10'h201, 10'h206};
`else
            m_act   = 1'b0;
`endif
            return;
        end
        ending      = m_act && (e - m_start == m_dur);
        idle_before = !m_act;
        pend_before = m_pend_v;
        took        = 1'b0;
        if (ending || (!m_act && m_pend_v)) begin
            if (ending && init_q.size() > 0) begin
                m_begin(init_q.pop_front());
            end else if (m_pend_v) begin
                m_begin(m_pend_w);
                m_pend_v = 1'b0;
                took     = 1'b1;
            end else begin
                m_act = 1'b0;
            end
        end
        if (wr) begin
            if (idle_before && !pend_before) m_begin(w);
            else if (!pend_before || took) begin
                m_pend_v = 1'b1;
                m_pend_w = w;
            end else m_ovf = 1'b1;
        end
    endfunction

    task automatic compare_all();
        int off;
        bit x_en;
        off  = e - m_start;
        x_en = m_act && !m_wait && off >= TS && off < TS + TP;
        check("data", o_lcd_data, m_cur[7:0]);
        check("rs", o_lcd_rs, m_cur[8]);
        check("on", o_lcd_on, m_cur[9]);
        check("rw", o_lcd_rw, 1'b0);
        check("en", o_lcd_en, x_en);
        check("busy", o_busy, m_act || m_pend_v);
        check("overflow", o_overflow, m_ovf);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_write(input logic [31:0] w);
        wr   = 1'b1;
        word = w;
        step();
        wr   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 300) begin
            step();
            n++;
        end
        if (n == 300) check("idle_timeout", o_busy, 1'b0);
    endtask

    // Counts busy/en samples from the current sample until busy falls (bounded).
    task automatic measure(output int bcnt, output int ecnt, output int first_en);
        bit done = 1'b0;
        bcnt = 0; ecnt = 0; first_en = -1;
        for (int n = 0; n < 300 && !done; n++) begin
            if (!o_busy) done = 1'b1;
            else begin
                bcnt++;
                if (o_lcd_en) begin
                    if (first_en < 0) first_en = n;
                    ecnt++;
                end
                step();
            end
        end
        if (!done) check("busy_timeout", o_busy, 1'b0);
    endtask

    initial begin
        int bc, ec, fe;
        logic [31:0] w;
        rst = 1'b1; wr = 1'b0; word = '0;
        repeat (3) step();
        rst = 1'b0;
        phase = "post_reset";
        repeat (10) step();
        wait_idle();

        phase = "write_141";
        do_write(32'h8000_0141);
        check("first_data", o_lcd_data, 8'h41);
        check("first_rs", o_lcd_rs, 1'b1);
        check("first_on", o_lcd_on, 1'b1);
        measure(bc, ec, fe);
        check("busy_cycles", bc, 12);
        check("en_cycles", ec, 3);
        check("en_offset", fe, 2);

        phase = "write_clear";
        do_write(32'h0000_0001);
        measure(bc, ec, fe);
        check("busy_cycles", bc, 27);
        check("en_cycles", ec, 3);

        phase = "burst";
        do_write(32'h0000_0141);
        do_write(32'h0000_0142);
        do_write(32'h0000_0143);
        // Current sample is two cycles into 0x41; 0x42 follows with no gap.
        measure(bc, ec, fe);
        check("busy_cycles", bc, 22);
        check("en_cycles", ec, 6);
        check("overflow_set", o_overflow, 1'b1);
        repeat (5) step();
        check("overflow_sticky", o_overflow, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("overflow_cleared", o_overflow, 1'b0);
        wait_idle();

        phase = "reset_in_pulse";
        do_write(32'h0000_0142);
        do_write(32'h0000_0143);
        step();
        check("en_in_pulse", o_lcd_en, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("en_after_reset", o_lcd_en, 1'b0);
        check("data_after_reset", o_lcd_data, 8'h00);
`ifndef LCD_INIT_EN
        check("busy_after_reset", o_busy, 1'b0);
        repeat (5) step();
        check("pending_lost", o_busy, 1'b0);
`endif
        wait_idle();

        phase = "random";
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            wr  = !rst && ($urandom_range(0, 2) == 0);
            w   = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                w[8]   = 1'b0;
                w[7:0] = 8'($urandom_range(1, 3));
            end
            word = w;
            step();
        end
        rst = 1'b0;
        wr  = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
